// File: rtl/uart_pkg.sv
// Shared definitions for the UART blocks: FSM encoding, line level
// and counter width helper.
package uart_pkg;

    localparam logic [2:0] ST_IDLE  = 3'd0;
    localparam logic [2:0] ST_START = 3'd1;
    localparam logic [2:0] ST_DATA  = 3'd2;
    localparam logic [2:0] ST_STOP  = 3'd3;
    localparam logic [2:0] ST_BREAK = 3'd4;

    typedef enum logic [2:0] {
        IDLE  = ST_IDLE,
        START = ST_START,
        DATA  = ST_DATA,
        STOP  = ST_STOP,
        BREAK = ST_BREAK
    } state_t;

    localparam logic LINE_IDLE = 1'b1;

    // Bits needed to count 0..n-1, never less than one.
    function automatic int cnt_width(input int n);
        return (n > 2) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchronizer for a single asynchronous input.
module sync_2ff #(
    parameter logic RESET_VAL = 1'b1
) (
    input  logic clk,
    input  logic reset,
    input  logic d,
    output logic q
);

    logic meta;

    always_ff @(posedge clk) begin
        if (!reset) begin
            meta <= RESET_VAL;
            q    <= RESET_VAL;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/uart_rx.sv
// Oversampling UART receiver: LSB-first frames, one stop bit,
// one-clock valid / frame_err pulses.
module uart_rx
    import uart_pkg::*;
#(
    parameter int OVERSAMPLE = 16,
    parameter int DATA_BITS  = 8
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 strobe,
    input  logic                 rx,
    output logic [DATA_BITS-1:0] data,
    output logic                 valid,
    output logic                 frame_err,
    output logic                 busy
);

    if (OVERSAMPLE < 4 || OVERSAMPLE > 256 || (OVERSAMPLE % 2) != 0) begin : g_bad_os
        $error("uart_rx: OVERSAMPLE must be even and within 4..256");
    end
    if (DATA_BITS < 5 || DATA_BITS > 9) begin : g_bad_db
        $error("uart_rx: DATA_BITS must be within 5..9");
    end

    localparam int TW = cnt_width(OVERSAMPLE);
    localparam int BW = cnt_width(DATA_BITS + 1);

    localparam logic [TW-1:0] T_MID  = TW'(OVERSAMPLE / 2 - 1);
    localparam logic [TW-1:0] T_END  = TW'(OVERSAMPLE - 1);
    localparam logic [BW-1:0] B_LAST = BW'(DATA_BITS - 1);

    state_t               state;
    logic [TW-1:0]        tick_cnt;
    logic [BW-1:0]        bit_cnt;
    logic [DATA_BITS-1:0] shreg;
    logic                 rx_s;

    sync_2ff #(
        .RESET_VAL(LINE_IDLE)
    ) u_sync (
        .clk  (clk),
        .reset(reset),
        .d    (rx),
        .q    (rx_s)
    );

    assign busy = (state != IDLE);

    always_ff @(posedge clk) begin
        if (!reset) begin
            state     <= IDLE;
            tick_cnt  <= '0;
            bit_cnt   <= '0;
            shreg     <= '0;
            data      <= '0;
            valid     <= 1'b0;
            frame_err <= 1'b0;
        end else begin
            valid     <= 1'b0;
            frame_err <= 1'b0;
            if (strobe) begin
                unique case (state)
                    IDLE: begin
                        if (rx_s != LINE_IDLE) begin
                            state    <= START;
                            tick_cnt <= '0;
                        end
                    end
                    START: begin
                        if (tick_cnt == T_MID) begin
                            if (rx_s == LINE_IDLE) begin
                                state <= IDLE;
                            end else begin
                                state    <= DATA;
                                tick_cnt <= '0;
                                bit_cnt  <= '0;
                            end
                        end else begin
                            tick_cnt <= tick_cnt + 1'b1;
                        end
                    end
                    DATA: begin
                        if (tick_cnt == T_END) begin
                            shreg    <= {rx_s, shreg[DATA_BITS-1:1]};
                            tick_cnt <= '0;
                            bit_cnt  <= bit_cnt + 1'b1;
                            if (bit_cnt == B_LAST) begin
                                state <= STOP;
                            end
                        end else begin
                            tick_cnt <= tick_cnt + 1'b1;
                        end
                    end
                    STOP: begin
                        if (tick_cnt == T_END) begin
                            tick_cnt <= '0;
                            if (rx_s == LINE_IDLE) begin
                                data  <= shreg;
                                valid <= 1'b1;
                                state <= IDLE;
                            end else begin
                                frame_err <= 1'b1;
                                state     <= BREAK;
                            end
                        end else begin
                            tick_cnt <= tick_cnt + 1'b1;
                        end
                    end
                    // Wait out a held-low line so it cannot re-trigger.
                    BREAK: begin
                        if (rx_s == LINE_IDLE) begin
                            state <= IDLE;
                        end
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_uart_rx.sv
// Scoreboard bench for uart_rx: directed scenarios plus random frames
// compared against an expected-event queue.
module tb_uart_rx;

    localparam int OS = 16;
    localparam int DB = 8;

    typedef struct {
        bit            is_err;
        logic [DB-1:0] data;
    } ev_t;

    logic          clk = 1'b0;
    logic          reset = 1'b0;
    logic          strobe = 1'b0;
    logic          rx = 1'b1;
    logic [DB-1:0] data;
    logic          valid;
    logic          frame_err;
    logic          busy;

    ev_t           sb[$];
    ev_t           ev;
    int            vstamp[$];
    int            checks = 0;
    int            errs = 0;
    int            scount = 0;
    int            ph = 0;
    bit            strobe_en = 1'b1;
    logic [DB-1:0] last_good = '0;

    uart_rx #(
        .OVERSAMPLE(OS),
        .DATA_BITS (DB)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .strobe   (strobe),
        .rx       (rx),
        .data     (data),
        .valid    (valid),
        .frame_err(frame_err),
        .busy     (busy)
    );

    always #5 clk = ~clk;

    // One strobe every third clock while enabled.
    initial begin
        forever begin
            @(negedge clk);
            if (strobe_en) begin
                ph = (ph + 1) % 3;
                strobe = (ph == 0);
            end else begin
                strobe = 1'b0;
            end
        end
    end

    initial begin
        forever begin
            @(posedge clk);
            if (strobe) scount++;
        end
    end

    initial begin
        #900000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errs++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Monitor: every output pulse must match the oldest expected event.
    initial begin
        forever begin
            @(negedge clk);
            if (valid && frame_err) begin
                checks++;
                errs++;
                $display("FAIL both_pulses: valid and frame_err high together");
            end else if (valid || frame_err) begin
                if (sb.size() == 0) begin
                    checks++;
                    errs++;
                    $display("FAIL unexpected_pulse: valid=%0b frame_err=%0b data=%0h",
                             valid, frame_err, data);
                end else begin
                    ev = sb.pop_front();
                    check("pulse_kind", 32'(frame_err), 32'(ev.is_err));
                    check("pulse_data", 32'(data), 32'(ev.data));
                    if (valid) vstamp.push_back(scount);
                end
            end
        end
    end

    task automatic wait_strobes(input int n);
        int k = 0;
        int cyc = 0;
        while (k < n && cyc < n * 4 + 8) begin
            @(posedge clk);
            cyc++;
            if (strobe) k++;
        end
        if (k < n) begin
            checks++;
            errs++;
            $display("FAIL strobe_timeout: got %0d strobes expected %0d", k, n);
        end
        @(negedge clk);
    endtask

    task automatic hold(input logic level, input int n);
        rx = level;
        wait_strobes(n);
    endtask

    task automatic send_frame(input logic [DB-1:0] b, input bit good);
        if (good) begin
            sb.push_back('{1'b0, b});
            last_good = b;
        end else begin
            sb.push_back('{1'b1, last_good});
        end
        hold(1'b0, OS);
        for (int i = 0; i < DB; i++) hold(b[i], OS);
        hold(good, OS);
    endtask

    task automatic drained(input string name);
        check(name, 32'(sb.size()), 32'd0);
    endtask

    initial begin
        logic [DB-1:0] b;
        bit            frozen_ok;
        int            n;
        int            t;

        repeat (4) @(negedge clk);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_data", 32'(data), 32'd0);
        check("rst_valid", 32'(valid), 32'd0);
        check("rst_frame_err", 32'(frame_err), 32'd0);
        reset = 1'b1;
        hold(1'b1, 20);

        send_frame(8'hA5, 1'b1);
        check("t1_busy_idle", 32'(busy), 32'd0);
        hold(1'b1, 8);
        drained("t1_drained");

        send_frame(8'h00, 1'b1);
        send_frame(8'hFF, 1'b1);
        hold(1'b1, 8);
        drained("t2_drained");
        n = vstamp.size();
        if (n >= 2) begin
            check("t2_spacing", 32'(vstamp[n-1] - vstamp[n-2]), 32'(OS * 10));
        end else begin
            checks++;
            errs++;
            $display("FAIL t2_spacing: got %0d valid pulses expected at least 2", n);
        end

        hold(1'b0, 4);
        check("t3_busy_detect", 32'(busy), 32'd1);
        hold(1'b0, 3);
        hold(1'b1, 8);
        check("t3_busy_clear", 32'(busy), 32'd0);
        hold(1'b1, 8);
        send_frame(8'h3C, 1'b1);
        hold(1'b1, 8);
        drained("t3_drained");

        send_frame(8'h55, 1'b0);
        hold(1'b0, 3 * OS);
        check("t4_busy_break", 32'(busy), 32'd1);
        check("t4_data_held", 32'(data), 32'h3C);
        hold(1'b1, OS);
        check("t4_busy_idle", 32'(busy), 32'd0);
        send_frame(8'h81, 1'b1);
        hold(1'b1, 8);
        drained("t4_drained");

        b = 8'hC3;
        hold(1'b0, OS);
        for (int i = 0; i < 4; i++) hold(b[i], OS);
        check("t5_busy_pre", 32'(busy), 32'd1);
        reset = 1'b0;
        rx = 1'b1;
        @(negedge clk);
        check("t5_busy", 32'(busy), 32'd0);
        check("t5_data", 32'(data), 32'd0);
        check("t5_valid", 32'(valid), 32'd0);
        reset = 1'b1;
        last_good = '0;
        hold(1'b1, OS);
        send_frame(8'h12, 1'b1);
        hold(1'b1, 8);
        drained("t5_drained");

        b = 8'h96;
        sb.push_back('{1'b0, b});
        last_good = b;
        hold(1'b0, OS);
        for (int i = 0; i < 3; i++) hold(b[i], OS);
        hold(b[3], 8);
        strobe_en = 1'b0;
        frozen_ok = 1'b1;
        repeat (50) begin
            @(negedge clk);
            if (!busy || valid || frame_err) frozen_ok = 1'b0;
        end
        check("t6_frozen", 32'(frozen_ok), 32'd1);
        strobe_en = 1'b1;
        hold(b[3], 8);
        for (int i = 4; i < DB; i++) hold(b[i], OS);
        hold(1'b1, OS);
        hold(1'b1, 8);
        drained("t6_drained");

        for (int it = 0; it < 24; it++) begin
            b = DB'($urandom);
            if ($urandom_range(0, 4) != 0) begin
                send_frame(b, 1'b1);
                hold(1'b1, $urandom_range(0, 4));
            end else begin
                send_frame(b, 1'b0);
                hold(1'b0, $urandom_range(0, 32));
                hold(1'b1, $urandom_range(3, 10));
            end
        end

        hold(1'b1, 8);
        t = 0;
        while (sb.size() != 0 && t < 2000) begin
            @(negedge clk);
            t++;
        end
        drained("final_drained");
        check("final_busy", 32'(busy), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", checks, errs);
        $finish;
    end

endmodule
